switch_debounce_enc_in: RTL
===========================

// Module: switch_debounce_enc_in
// PURPOSE
//  Conditions the four raw request switches and the enable switch that feed
//  the 4-to-2 priority encoder (I[3:0], Ein). Each channel gets a 2-FF
//  synchronizer and a per-channel stability counter, so the encoder sees only
//  clean, clock-aligned levels. One-cycle edge pulses go to downstream logic.
// PARAMETERS
//  WIDTH      4   number of request channels (drives encoder I)
//  DB_CYCLES  4   consecutive mismatching edges needed to accept a new level (>=2)
//  CNT_W      3   counter width; 2**CNT_W >= DB_CYCLES required
// PORTS
//  clk        in   1      system clock, all state on rising edge
//  rst        in   1      synchronous, active-high reset
//  raw_i      in   WIDTH  asynchronous request switches
//  raw_en     in   1      asynchronous enable switch
//  I          out  WIDTH  debounced requests -> encoder I
//  Ein        out  1      debounced enable -> encoder Ein
//  rise       out  WIDTH  1-cycle pulse: I[k] accepted 0->1
//  fall       out  WIDTH  1-cycle pulse: I[k] accepted 1->0
//  changed    out  1      1-cycle pulse: any bit of {Ein,I} accepted a new level
// BEHAVIOUR
//  - Channels: WIDTH request channels plus the enable channel. All are
//    identical and independent. Each has sync1, sync2, stable, cnt[CNT_W-1:0].
//  - Every edge: sync1<=raw, sync2<=sync1.
//  - If sync2==stable: cnt<=0. Otherwise, if cnt==DB_CYCLES-1: stable<=sync2
//    and cnt<=0. Otherwise cnt<=cnt+1. cnt never exceeds DB_CYCLES-1.
//  - Outputs are registered: I, Ein = stable. Pulses are asserted in the cycle
//    after the edge that updates stable, for exactly one cycle.
//  - Latency: raw is first sampled at edge E0 and held. stable updates at edge
//    E0+DB_CYCLES+1, so I/Ein show the new level after DB_CYCLES+2 edges.
//  - Glitch rejection: a mismatch lasting < DB_CYCLES consecutive sync2
//    samples clears cnt. There is no output change and no pulse.
//  - rise/fall of a channel are mutually exclusive. changed = OR of all
//    channel updates, Ein included. Several channels may update on the same
//    edge; changed still pulses once.
//  - Reset: sync1, sync2, stable, cnt, I, Ein, rise, fall and changed are all
//    0 after the first edge with rst=1. Reset mid-count discards progress.
//    After rst falls, a held raw level needs the full DB_CYCLES+2 edges.
//    Because the reset value is 0, a raw level already high at reset release
//    produces a rise pulse once accepted.
//  - No combinational path from any input to any output.
// TESTING  (DB_CYCLES=4, so latency = 6 edges)
//  1. rst=1 for 2 cycles, raw_i=4'b1111, raw_en=1 -> I=0, Ein=0, no pulses
//     while rst=1. After release: I=4'hF and Ein=1 on the 6th edge; rise=4'hF
//     and changed=1 for one cycle.
//  2. From idle, raw_i=4'b1000 held -> I still 0 after edge 5. I=4'b1000
//     after edge 6. rise=4'b1000 and changed=1 for one cycle. fall stays 0.
//  3. raw_i[2] high for 3 cycles then low -> I, rise, fall and changed all
//     stay 0 throughout.
//  4. I=4'b1000 stable, raw_i->0 -> I=0 after 6 edges. fall=4'b1000 for one
//     cycle, rise=0.
//  5. raw_i=4'b0001 and raw_en=1 on the same edge -> I[0] and Ein go high on
//     the same edge, with a single 1-cycle changed pulse.
//  6. raw_i=4'b0100 for 4 edges, then rst=1 for 1 cycle with raw held -> I
//     stays 0 and cnt=0. I=4'b0100 exactly 6 edges after rst deasserts.

Source files
------------

// File: rtl/switch_debounce_enc_in_if.sv
// Switch/encoder-side bundle for switch_debounce_enc_in.
// raw_i/raw_en from switches; I/Ein/rise/fall/changed to the encoder.
interface switch_debounce_enc_in_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] raw_i;
  logic             raw_en;
  logic [WIDTH-1:0] I;
  logic             Ein;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             changed;

  modport master (
    output raw_i,
    output raw_en,
    input  I,
    input  Ein,
    input  rise,
    input  fall,
    input  changed
  );

  modport slave (
    input  raw_i,
    input  raw_en,
    output I,
    output Ein,
    output rise,
    output fall,
    output changed
  );
endinterface

// File: rtl/switch_debounce_enc_in.sv
// Debounces WIDTH request switches plus the enable switch for a priority
// encoder.
// Ports: clk, rst (sync, active-high), bus (slave): raw_i/raw_en in;
// I/Ein levels, rise/fall/changed one-cycle pulses out.
module switch_debounce_enc_in #(
  parameter int WIDTH     = 4,
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  switch_debounce_enc_in_if.slave bus
);

  localparam int N = WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(DB_CYCLES - 1);

  if (DB_CYCLES < 2) begin : g_chk_db
    $error("DB_CYCLES must be >= 2");
  end
  if ((2 ** CNT_W) < DB_CYCLES) begin : g_chk_cnt
    $error("CNT_W too narrow for DB_CYCLES");
  end

  // Channel WIDTH is the enable; the rest are requests.
  logic [N-1:0]     raw;
  logic [N-1:0]     sync1;
  logic [N-1:0]     sync2;
  logic [N-1:0]     stable;
  logic [N-1:0]     accept;
  logic [CNT_W-1:0] cnt [N];

  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;
  logic             changed_q;

  assign raw = {bus.raw_en, bus.raw_i};

  // A new level is taken on the DB_CYCLES-th
  // consecutive mismatching sync2 sample.
  always_comb begin
    accept = '0;
    for (int c = 0; c < N; c++) begin
      accept[c] = (sync2[c] != stable[c]) &&
                  (cnt[c] == LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= '0;
      sync2     <= '0;
      stable    <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
      for (int c = 0; c < N; c++) begin
        cnt[c] <= '0;
      end
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int c = 0; c < N; c++) begin
        if (sync2[c] == stable[c]) begin
          cnt[c] <= '0;
        end else if (accept[c]) begin
          cnt[c]    <= '0;
          stable[c] <= sync2[c];
        end else begin
          cnt[c] <= cnt[c] + 1'b1;
        end
      end
      rise_q    <= accept[WIDTH-1:0] &
                   sync2[WIDTH-1:0];
      fall_q    <= accept[WIDTH-1:0] &
                   ~sync2[WIDTH-1:0];
      changed_q <= |accept;
    end
  end

  assign bus.I       = stable[WIDTH-1:0];
  assign bus.Ein     = stable[WIDTH];
  assign bus.rise    = rise_q;
  assign bus.fall    = fall_q;
  assign bus.changed = changed_q;

endmodule
